// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory slave between the boot
// loader (m0), the core data port (m1) and the core fetch port (m2).
// One transaction in flight at a time: select owner, issue, wait for response.
// Handshake outputs are decoded from registered state so that gnt/rvalid line
// up with the slave's s_gnt/s_rvalid in the same cycle.
module mem_bus_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_err,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_err,
   input  logic                  m2_req,
   input  logic                  m2_we,
   input  logic [ADDR_WIDTH-1:0] m2_addr,
   input  logic [DATA_WIDTH-1:0] m2_wdata,
   output logic                  m2_gnt,
   output logic                  m2_rvalid,
   output logic [DATA_WIDTH-1:0] m2_rdata,
   output logic                  m2_err,
   output logic                  s_req,
   output logic                  s_we,
   output logic [ADDR_WIDTH-1:0] s_addr,
   output logic [DATA_WIDTH-1:0] s_wdata,
   input  logic                  s_gnt,
   input  logic                  s_rvalid,
   input  logic [DATA_WIDTH-1:0] s_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] OWN_M0   = 2'd0;
   localparam logic [1:0] OWN_M1   = 2'd1;
   localparam logic [1:0] OWN_M2   = 2'd2;
   localparam logic [1:0] OWN_NONE = 2'd3;

   // Counter value on the last permitted WAIT cycle: the error fires on the
   // TIMEOUT-th WAIT cycle if the slave is still silent.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t          state_reg;
   logic [1:0]      owner_reg;
   logic            rr_ptr_reg;      // 0: m1 preferred next, 1: m2 preferred next
   logic [7:0]      cnt_reg;

   logic [1:0]      sel_owner;
   logic            own_we;
   logic [ADDR_WIDTH-1:0] own_addr;
   logic [DATA_WIDTH-1:0] own_wdata;

   logic            live;
   logic            issue_acc;
   logic            resp_ok;
   logic            resp_timeout;
   logic            resp_done;

   logic [2:0]            gnt_vec;
   logic [2:0]            rvalid_vec;
   logic [2:0]            err_vec;
   logic [DATA_WIDTH-1:0] rdata_arr [3];

   // Owner selection for the IDLE cycle: loader first, then m1/m2 round-robin
   always_comb begin
      sel_owner = OWN_NONE;
      if (m0_req) begin
         sel_owner = OWN_M0;
      end else if (m1_req && m2_req) begin
         sel_owner = rr_ptr_reg ? OWN_M2 : OWN_M1;
      end else if (m1_req) begin
         sel_owner = OWN_M1;
      end else if (m2_req) begin
         sel_owner = OWN_M2;
      end
   end

   // Route the current owner's live request fields towards the slave
   always_comb begin
      own_we    = 1'b0;
      own_addr  = '0;
      own_wdata = '0;
      case (owner_reg)
         OWN_M0: begin
            own_we    = m0_we;
            own_addr  = m0_addr;
            own_wdata = m0_wdata;
         end
         OWN_M1: begin
            own_we    = m1_we;
            own_addr  = m1_addr;
            own_wdata = m1_wdata;
         end
         OWN_M2: begin
            own_we    = m2_we;
            own_addr  = m2_addr;
            own_wdata = m2_wdata;
         end
         default: begin
            own_we    = 1'b0;
            own_addr  = '0;
            own_wdata = '0;
         end
      endcase
   end

   // While reset is held every output is forced low, even mid-transaction
   assign live         = !rst_n;
   assign issue_acc    = (state_reg == ST_ISSUE) && s_gnt;
   assign resp_ok      = (state_reg == ST_WAIT) && s_rvalid;
   assign resp_timeout = (state_reg == ST_WAIT) && !s_rvalid && (cnt_reg == CNT_LAST);
   assign resp_done    = resp_ok || resp_timeout;

   assign s_req   = live && (state_reg == ST_ISSUE);
   assign s_we    = s_req && own_we;
   assign s_addr  = s_req ? own_addr  : '0;
   assign s_wdata = s_req ? own_wdata : '0;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_resp
         logic is_owner;
         assign is_owner       = live && (owner_reg == 2'(gi));
         assign gnt_vec[gi]    = is_owner && issue_acc;
         assign rvalid_vec[gi] = is_owner && resp_done;
         assign err_vec[gi]    = is_owner && resp_timeout;
         assign rdata_arr[gi]  = (is_owner && resp_ok) ? s_rdata : '0;
      end
   endgenerate

   assign m0_gnt    = gnt_vec[0];
   assign m1_gnt    = gnt_vec[1];
   assign m2_gnt    = gnt_vec[2];
   assign m0_rvalid = rvalid_vec[0];
   assign m1_rvalid = rvalid_vec[1];
   assign m2_rvalid = rvalid_vec[2];
   assign m0_err    = err_vec[0];
   assign m1_err    = err_vec[1];
   assign m2_err    = err_vec[2];
   assign m0_rdata  = rdata_arr[0];
   assign m1_rdata  = rdata_arr[1];
   assign m2_rdata  = rdata_arr[2];

   // Transaction sequencer: select, issue until accepted, wait for response
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg  <= ST_IDLE;
         owner_reg  <= OWN_NONE;
         rr_ptr_reg <= 1'b0;
         cnt_reg    <= 8'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (sel_owner != OWN_NONE) begin
                  owner_reg <= sel_owner;
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (s_gnt) begin
                  cnt_reg   <= 8'd0;
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (resp_done) begin
                  state_reg <= ST_IDLE;
                  owner_reg <= OWN_NONE;
                  if (owner_reg == OWN_M1) begin
                     rr_ptr_reg <= 1'b1;
                  end else if (owner_reg == OWN_M2) begin
                     rr_ptr_reg <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               owner_reg <= OWN_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: scenario tasks plus a randomized run checked
// against a transaction-level model (priority/round-robin pick, timeout rule).
module tb_mem_bus_arbiter;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        mreq [3];
   logic        mwe  [3];
   logic [31:0] maddr [3];
   logic [31:0] mwdata [3];

   logic        m0_gnt, m1_gnt, m2_gnt;
   logic        m0_rvalid, m1_rvalid, m2_rvalid;
   logic        m0_err, m1_err, m2_err;
   logic [31:0] m0_rdata, m1_rdata, m2_rdata;
   logic        s_req, s_we;
   logic [31:0] s_addr, s_wdata;
   logic        s_gnt, s_rvalid;
   logic [31:0] s_rdata;

   mem_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(mreq[0]), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(mreq[1]), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .m2_req(mreq[2]), .m2_we(mwe[2]), .m2_addr(maddr[2]), .m2_wdata(mwdata[2]),
      .m2_gnt(m2_gnt), .m2_rvalid(m2_rvalid), .m2_rdata(m2_rdata), .m2_err(m2_err),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
   );

   logic [2:0] gnt_now, rv_now, err_now;
   logic       rd_nz, bus_nz, out_nz;
   assign gnt_now = {m2_gnt, m1_gnt, m0_gnt};
   assign rv_now  = {m2_rvalid, m1_rvalid, m0_rvalid};
   assign err_now = {m2_err, m1_err, m0_err};
   assign rd_nz   = (m0_rdata != 0) || (m1_rdata != 0) || (m2_rdata != 0);
   assign bus_nz  = s_we || (s_addr != 0) || (s_wdata != 0);
   assign out_nz  = (gnt_now != 0) || (rv_now != 0) || (err_now != 0) || rd_nz || s_req || bus_nz;

   int vectors = 0;
   int miscompares = 0;
   int exp_rr = 1;   // model: which of m1/m2 wins a tie next

   // observations recorded by the slave-side driver for one transaction
   logic [2:0]  obs_gnt, obs_rv, obs_err;
   int          obs_gcyc, obs_wait, obs_viol;
   logic [31:0] obs_addr, obs_wdata;
   logic        obs_we;
   logic [31:0] obs_rd [3];

   function automatic int predict(input logic [2:0] rq);
      if (rq[0]) return 0;
      if (rq[1] && rq[2]) return exp_rr;
      if (rq[1]) return 1;
      if (rq[2]) return 2;
      return -1;
   endfunction

   function automatic void served(input int own);
      if (own == 1) exp_rr = 2;
      else if (own == 2) exp_rr = 1;
   endfunction

   task automatic clr_masters();
      for (int k = 0; k < 3; k++) begin
         mreq[k] = 1'b0; mwe[k] = 1'b0; maddr[k] = '0; mwdata[k] = '0;
      end
   endtask

   task automatic rand_master(input int k, input logic rq);
      mreq[k]   = rq;
      mwe[k]    = 1'($urandom_range(0, 1));
      maddr[k]  = $urandom;
      mwdata[k] = $urandom;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      next_cycle();
      next_cycle();
      rst_n = 1'b0;
      exp_rr = 1;
   endtask

   // Slave-side driver: starts in the IDLE cycle, returns in the following IDLE cycle.
   task automatic slave_txn(input int gnt_dly, input bit respond, input int rsp_dly,
                            input logic [31:0] rsp_data);
      logic [31:0] first_addr;
      bit          seen;
      first_addr = '0;
      seen = 0;
      obs_gnt = '0; obs_rv = '0; obs_err = '0; obs_gcyc = -1; obs_wait = -1; obs_viol = 0;
      obs_addr = '0; obs_wdata = '0; obs_we = 1'b0;
      for (int k = 0; k < 3; k++) obs_rd[k] = '0;
      s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = $urandom;
      @(negedge clk);
      if (out_nz) obs_viol++;
      next_cycle();
      for (int i = 0; i <= gnt_dly; i++) begin
         s_gnt = (i == gnt_dly);
         s_rdata = $urandom;
         @(negedge clk);
         if (i == 0) first_addr = s_addr;
         if (s_req !== 1'b1 || s_addr !== first_addr || rv_now != 0 || err_now != 0 || rd_nz)
            obs_viol++;
         if (i < gnt_dly) begin
            if (gnt_now != 0) obs_viol++;
         end else begin
            obs_gnt = gnt_now; obs_gcyc = i + 1;
            obs_addr = s_addr; obs_we = s_we; obs_wdata = s_wdata;
         end
         next_cycle();
      end
      s_gnt = 1'b0;
      for (int j = 0; j < 300; j++) begin
         s_rvalid = respond && (j == rsp_dly);
         s_rdata  = s_rvalid ? rsp_data : $urandom;
         @(negedge clk);
         if (s_req || bus_nz || gnt_now != 0) obs_viol++;
         if (rv_now != 0) begin
            obs_rv = rv_now; obs_err = err_now; obs_wait = j + 1;
            obs_rd[0] = m0_rdata; obs_rd[1] = m1_rdata; obs_rd[2] = m2_rdata;
            seen = 1;
         end else if (err_now != 0 || rd_nz) begin
            obs_viol++;
         end
         next_cycle();
         if (seen) break;
      end
      s_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         for (int k = 0; k < 3; k++) rand_master(k, 1'b1);
         s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = $urandom;
         @(negedge clk);
         vectors++;
         if (out_nz) begin
            miscompares++;
            $display("FAIL reset_outputs cycle %0d: gnt=%b rv=%b err=%b s_req=%b, required all zero",
                     c, gnt_now, rv_now, err_now, s_req);
         end
         next_cycle();
      end
      clr_masters();
      rst_n = 1'b0;
      exp_rr = 1;
      for (int c = 0; c < 2; c++) begin
         s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = $urandom;
         @(negedge clk);
         vectors++;
         if (out_nz) begin
            miscompares++;
            $display("FAIL idle_after_reset cycle %0d: rv=%b s_req=%b, required all zero", c, rv_now, s_req);
         end
         next_cycle();
      end
      s_gnt = 1'b0; s_rvalid = 1'b0;
   endtask

   task automatic test_single_read();
      clr_masters();
      mreq[2] = 1'b1; mwe[2] = 1'b0; maddr[2] = 32'h0000_0010; mwdata[2] = $urandom;
      slave_txn(0, 1, 2, 32'hDEAD_BEEF);
      served(2);
      mreq[2] = 1'b0;
      vectors++;
      if (obs_gnt !== 3'b100 || obs_gcyc != 1) begin
         miscompares++;
         $display("FAIL single_gnt: got mask %b at cycle %0d, required 100 at cycle 1", obs_gnt, obs_gcyc);
      end
      vectors++;
      if (obs_addr !== 32'h10 || obs_we !== 1'b0) begin
         miscompares++;
         $display("FAIL single_issue: got addr %h we %b, required 00000010 we 0", obs_addr, obs_we);
      end
      vectors++;
      if (obs_rv !== 3'b100 || obs_err !== 3'b000 || obs_wait != 3) begin
         miscompares++;
         $display("FAIL single_rvalid: got rv %b err %b after %0d, required 100 000 after 3",
                  obs_rv, obs_err, obs_wait);
      end
      vectors++;
      if (obs_rd[2] !== 32'hDEAD_BEEF || obs_rd[0] !== 0 || obs_rd[1] !== 0) begin
         miscompares++;
         $display("FAIL single_rdata: got m2 %h m1 %h m0 %h, required deadbeef 0 0",
                  obs_rd[2], obs_rd[1], obs_rd[0]);
      end
      vectors++;
      if (obs_viol != 0) begin
         miscompares++;
         $display("FAIL single_protocol: got %0d stray cycles, required 0", obs_viol);
      end
   endtask

   task automatic test_priority();
      int own;
      for (int k = 0; k < 3; k++) rand_master(k, 1'b1);
      mwe[0] = 1'b1;
      for (int t = 0; t < 4; t++) begin
         slave_txn($urandom_range(0, 2), 1, $urandom_range(0, 3), $urandom);
         vectors++;
         if (obs_gnt !== 3'b001) begin
            miscompares++;
            $display("FAIL prio_owner txn %0d: got %b, required 001", t, obs_gnt);
         end
         vectors++;
         if (obs_we !== 1'b1 || obs_addr !== maddr[0] || obs_wdata !== mwdata[0]) begin
            miscompares++;
            $display("FAIL prio_issue txn %0d: got we %b addr %h data %h, required 1 %h %h",
                     t, obs_we, obs_addr, obs_wdata, maddr[0], mwdata[0]);
         end
         vectors++;
         if (obs_viol != 0 || obs_rv !== 3'b001) begin
            miscompares++;
            $display("FAIL prio_protocol txn %0d: got viol %0d rv %b, required 0 001", t, obs_viol, obs_rv);
         end
         maddr[0] = $urandom; mwdata[0] = $urandom;
      end
      mreq[0] = 1'b0;
      own = predict({mreq[2], mreq[1], mreq[0]});
      slave_txn(0, 1, 0, $urandom);
      vectors++;
      if (obs_gnt !== 3'(1 << own)) begin
         miscompares++;
         $display("FAIL prio_after_loader: got %b, required %b", obs_gnt, 3'(1 << own));
      end
      served(own);
      clr_masters();
   endtask

   task automatic test_round_robin();
      logic [2:0] want;
      do_reset();
      clr_masters();
      rand_master(1, 1'b1);
      rand_master(2, 1'b1);
      for (int t = 0; t < 8; t++) begin
         want = (t % 2 == 0) ? 3'b010 : 3'b100;
         slave_txn($urandom_range(0, 2), 1, $urandom_range(0, 3), $urandom);
         vectors++;
         if (obs_gnt !== want || obs_rv !== want || obs_viol != 0) begin
            miscompares++;
            $display("FAIL rr_order txn %0d: got gnt %b rv %b viol %0d, required %b %b 0",
                     t, obs_gnt, obs_rv, obs_viol, want, want);
         end
         rand_master(1, 1'b1);
         rand_master(2, 1'b1);
      end
      exp_rr = 1;
      clr_masters();
   endtask

   task automatic test_backpressure();
      clr_masters();
      rand_master(1, 1'b1);
      slave_txn(10, 1, 0, $urandom);
      served(1);
      vectors++;
      if (obs_gnt !== 3'b010 || obs_gcyc != 11) begin
         miscompares++;
         $display("FAIL bp_gnt: got %b at cycle %0d, required 010 at cycle 11", obs_gnt, obs_gcyc);
      end
      vectors++;
      if (obs_addr !== maddr[1] || obs_viol != 0) begin
         miscompares++;
         $display("FAIL bp_hold: got addr %h viol %0d, required %h 0", obs_addr, obs_viol, maddr[1]);
      end
      clr_masters();
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      clr_masters();
      rand_master(1, 1'b1); mwe[1] = 1'b0;
      slave_txn(0, 0, 0, 32'h0);
      served(1);
      mreq[1] = 1'b0;
      vectors++;
      if (obs_rv !== 3'b010 || obs_err !== 3'b010 || obs_rd[1] !== 0 || obs_wait != TO) begin
         miscompares++;
         $display("FAIL timeout_err: got rv %b err %b rdata %h after %0d, required 010 010 0 after %0d",
                  obs_rv, obs_err, obs_rd[1], obs_wait, TO);
      end
      d = $urandom;
      rand_master(2, 1'b1);
      slave_txn(1, 1, 1, d);
      served(2);
      mreq[2] = 1'b0;
      vectors++;
      if (obs_gnt !== 3'b100 || obs_rv !== 3'b100 || obs_err !== 0 || obs_rd[2] !== d) begin
         miscompares++;
         $display("FAIL timeout_recover: got gnt %b rv %b err %b rdata %h, required 100 100 000 %h",
                  obs_gnt, obs_rv, obs_err, obs_rd[2], d);
      end
      d = $urandom;
      rand_master(1, 1'b1);
      slave_txn(0, 1, TO - 1, d);
      served(1);
      vectors++;
      if (obs_rv !== 3'b010 || obs_err !== 0 || obs_rd[1] !== d || obs_wait != TO) begin
         miscompares++;
         $display("FAIL timeout_edge: got rv %b err %b rdata %h after %0d, required 010 000 %h after %0d",
                  obs_rv, obs_err, obs_rd[1], obs_wait, d, TO);
      end
      clr_masters();
   endtask

   task automatic test_reset_midop();
      clr_masters();
      rand_master(2, 1'b1); mwe[2] = 1'b0;
      s_gnt = 1'b0; s_rvalid = 1'b0;
      next_cycle();                       // IDLE: select m2
      s_gnt = 1'b1;
      @(negedge clk);
      vectors++;
      if (gnt_now !== 3'b100) begin
         miscompares++;
         $display("FAIL midop_gnt: got %b, required 100", gnt_now);
      end
      next_cycle();
      s_gnt = 1'b0; mreq[2] = 1'b0;
      next_cycle();                       // first WAIT cycle, no response
      rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         s_rvalid = 1'b1; s_rdata = $urandom;
         @(negedge clk);
         vectors++;
         if (out_nz) begin
            miscompares++;
            $display("FAIL midop_reset cycle %0d: got rv %b s_req %b rdata_nz %b, required all zero",
                     c, rv_now, s_req, rd_nz);
         end
         next_cycle();
      end
      rst_n = 1'b0;
      exp_rr = 1;
      s_rvalid = 1'b1; s_rdata = $urandom;
      @(negedge clk);
      vectors++;
      if (out_nz) begin
         miscompares++;
         $display("FAIL midop_late_rvalid: got rv %b rdata_nz %b, required 000 0", rv_now, rd_nz);
      end
      next_cycle();
      s_rvalid = 1'b0;
      rand_master(1, 1'b1);
      rand_master(2, 1'b1);
      slave_txn(0, 1, 0, $urandom);
      served(1);
      vectors++;
      if (obs_gnt !== 3'b010 || obs_rv !== 3'b010) begin
         miscompares++;
         $display("FAIL midop_rr_restart: got gnt %b rv %b, required 010 010", obs_gnt, obs_rv);
      end
      clr_masters();
   endtask

   task automatic test_random();
      int own, gd, rd, exp_wait;
      bit resp, timed;
      logic [2:0] rq, oh;
      logic [31:0] d, exp_d;
      for (int t = 0; t < 40; t++) begin
         rq = 3'($urandom_range(1, 7));
         for (int k = 0; k < 3; k++) rand_master(k, rq[k]);
         own  = predict(rq);
         oh   = 3'(1 << own);
         gd   = $urandom_range(0, 3);
         resp = ($urandom_range(0, 9) != 0);
         rd   = $urandom_range(0, 9);
         d    = $urandom;
         timed    = !resp || (rd > TO - 1);
         exp_wait = timed ? TO : rd + 1;
         slave_txn(gd, resp, rd, d);
         vectors++;
         if (obs_gnt !== oh || obs_gcyc != gd + 1) begin
            miscompares++;
            $display("FAIL rand_gnt txn %0d: got %b at %0d, required %b at %0d", t, obs_gnt, obs_gcyc, oh, gd + 1);
         end
         vectors++;
         if ({obs_we, obs_addr, obs_wdata} !== {mwe[own], maddr[own], mwdata[own]}) begin
            miscompares++;
            $display("FAIL rand_issue txn %0d: got %b %h %h, required %b %h %h", t,
                     obs_we, obs_addr, obs_wdata, mwe[own], maddr[own], mwdata[own]);
         end
         vectors++;
         if (obs_rv !== oh || obs_err !== (timed ? oh : 3'b000) || obs_wait != exp_wait) begin
            miscompares++;
            $display("FAIL rand_resp txn %0d: got rv %b err %b after %0d, required %b %b after %0d",
                     t, obs_rv, obs_err, obs_wait, oh, timed ? oh : 3'b000, exp_wait);
         end
         for (int k = 0; k < 3; k++) begin
            exp_d = (k == own && !timed) ? d : 32'h0;
            vectors++;
            if (obs_rd[k] !== exp_d) begin
               miscompares++;
               $display("FAIL rand_rdata txn %0d m%0d: got %h, required %h", t, k, obs_rd[k], exp_d);
            end
         end
         vectors++;
         if (obs_viol != 0) begin
            miscompares++;
            $display("FAIL rand_protocol txn %0d: got %0d stray cycles, required 0", t, obs_viol);
         end
         served(own);
      end
      clr_masters();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_masters();
      s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      rst_n = 1'b1;
      #1;
      test_reset();
      test_single_read();
      test_priority();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port SoC memory slave between three masters:
  - m0: program loader, used at boot to fill instruction memory.
  - m1: core data load/store port.
  - m2: core instruction fetch port.
- One transaction outstanding at a time. Registered owner selection, then request issue, then response wait with timeout.
- Sits in soc_top between riscv_core and the rom/ram instances, replacing direct wiring.

Parameters:
- DATA_WIDTH, 32, width of wdata/rdata.
- ADDR_WIDTH, 32, width of addresses.
- TIMEOUT, 255, maximum WAIT cycles before an error response (1..255; 8-bit counter).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-high (1 = reset asserted, equal to `RstEnable).
- mN_req  in  1  request, N=0,1,2. Master holds req/we/addr/wdata stable until mN_gnt.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_WIDTH  byte address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_gnt  out  1  one-cycle pulse: request accepted by slave.
- mN_rvalid  out  1  one-cycle pulse: response for mN.
- mN_rdata  out  DATA_WIDTH  read data, valid with mN_rvalid; 0 otherwise.
- mN_err  out  1  pulse together with mN_rvalid when the response timed out.
- s_req  out  1  request to slave.
- s_we  out  1  write enable to slave.
- s_addr  out  ADDR_WIDTH  address to slave.
- s_wdata  out  DATA_WIDTH  write data to slave.
- s_gnt  in  1  slave accepts the request this cycle.
- s_rvalid  in  1  slave response, for reads and writes.
- s_rdata  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset: state=IDLE, owner=none, rr_ptr=m1, timeout counter=0.
- Reset outputs: all mN_gnt/rvalid/err=0, all mN_rdata=0, s_req/s_we=0, s_addr/s_wdata=0.
- Reset mid-transaction abandons it with no response. A late s_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any mN_req=1, latch owner and go to ISSUE next cycle. s_req stays 0 in IDLE. Selection rule:
  - m0 has absolute priority.
  - Otherwise m1/m2 round-robin: if both request, pick the one rr_ptr points to; if only one requests, pick it.
- ISSUE:
  - s_req=1; s_we/s_addr/s_wdata are driven from the owner's live inputs.
  - When s_gnt=1: pulse owner's mN_gnt in the same cycle, clear counter, go to WAIT.
  - Stay in ISSUE while s_gnt=0. There is no timeout in ISSUE.
  - After ISSUE exit, s_req=0 and s_addr/s_we/s_wdata return to 0.
- WAIT:
  - When s_rvalid=1: pulse owner's mN_rvalid, set mN_rdata=s_rdata that cycle, go to IDLE.
  - If owner is m1 or m2, toggle rr_ptr to the other.
  - Else increment counter. If counter reaches TIMEOUT with no s_rvalid: pulse mN_rvalid and mN_err with rdata=0, go to IDLE; rr_ptr updates as for a normal response.
- s_rvalid in the same cycle as the timeout expiry counts as a normal response (err=0).
- Minimum latency req to gnt: 2 cycles (IDLE select, ISSUE with s_gnt=1). Minimum latency gnt to rvalid: 1 cycle.
- Back-to-back: a master holding req is re-arbitrated in the IDLE cycle after its rvalid. Every transaction costs at least 1 idle cycle.
- Non-owner masters see gnt=0, rvalid=0 and rdata=0 throughout.
- A master dropping req during ISSUE is a protocol violation. The arbiter still completes the issue with the owner's current inputs.

Test Plan:
- Single read: m2 reads addr 0x0000_0010; slave grants in ISSUE and returns rdata 0xDEAD_BEEF 3 cycles later -> m2_gnt pulse at cycle 2 after req, then m2_rvalid=1 and m2_rdata=0xDEAD_BEEF for exactly 1 cycle; other masters silent.
- Loader priority: m0, m1 and m2 all request continuously with 4 writes each from m0 -> all 4 m0 writes complete before any m1/m2 gnt; s_we=1 and s_addr matches m0_addr on each issue.
- Round-robin: m1 and m2 request continuously and m0 idle -> grants alternate m1, m2, m1, m2 starting with m1 after reset.
- Slave backpressure: s_gnt held 0 for 10 cycles in ISSUE -> s_req stays 1 with stable addr, no gnt pulse; gnt pulses on the cycle s_gnt=1.
- Timeout: with TIMEOUT=8, m1 read granted and slave never asserts s_rvalid -> 8 cycles later m1_rvalid=1, m1_err=1, m1_rdata=0; FSM in IDLE and next m2 request served normally.
- Reset mid-op: assert rst_n during WAIT of an m2 read and release after 2 cycles -> all outputs 0 during reset, no m2_rvalid, late s_rvalid ignored; next simultaneous m1/m2 requests grant m1 first.
